// File: rtl/lsu_stbuf_if.sv
// ============================================================================
// Module  : lsu_stbuf_if
// Brief   : Pipeline request/response and data-bus signal bundle for lsu_stbuf.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface lsu_stbuf_if #(
    parameter int XLEN     = 32,
    parameter int SB_DEPTH = 4
);
    localparam int BE_W  = XLEN / 8;
    localparam int CNT_W = $clog2(SB_DEPTH) + 1;

    logic             req_valid;
    logic             req_ready;
    logic             req_ld;
    logic             req_st;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [XLEN-1:0]  req_addr;
    logic [XLEN-1:0]  req_wdata;
    logic             flush;
    logic             rsp_valid;
    logic [XLEN-1:0]  rsp_rdata;
    logic             rsp_misaligned;
    logic             dbus_req;
    logic             dbus_we;
    logic [XLEN-1:0]  dbus_addr;
    logic [XLEN-1:0]  dbus_wdata;
    logic [BE_W-1:0]  dbus_be;
    logic             dbus_ack;
    logic [XLEN-1:0]  dbus_rdata;
    logic [CNT_W-1:0] sb_count;

    // Requester/bus-responder side
    modport master (
        output req_valid, req_ld, req_st, req_size, req_unsigned, req_addr,
               req_wdata, flush, dbus_ack, dbus_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned, dbus_req,
               dbus_we, dbus_addr, dbus_wdata, dbus_be, sb_count
    );

    // Store-buffer side
    modport slave (
        input  req_valid, req_ld, req_st, req_size, req_unsigned, req_addr,
               req_wdata, flush, dbus_ack, dbus_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_misaligned, dbus_req,
               dbus_we, dbus_addr, dbus_wdata, dbus_be, sb_count
    );
endinterface

`default_nettype wire

// File: rtl/lsu_stbuf.sv
// ============================================================================
// Module  : lsu_stbuf
// Brief   : Load/store unit with a store buffer, load forwarding and a
//           single-outstanding data-bus port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_stbuf #(
    parameter int XLEN     = 32,
    parameter int SB_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    lsu_stbuf_if.slave   bus
);
    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SB_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LD_BUS   = 2'd1,
        S_ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_sb_addr [SB_DEPTH];
    logic [XLEN-1:0]   r_sb_data [SB_DEPTH];
    logic [BE_W-1:0]   r_sb_be   [SB_DEPTH];
    logic [SB_DEPTH-1:0] r_sb_vld;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              r_rsp_valid;
    logic              r_rsp_mis;
    logic [XLEN-1:0]   r_rsp_rdata;
    logic              r_dbus_req;
    logic              r_dbus_we;
    logic [XLEN-1:0]   r_dbus_addr;
    logic [XLEN-1:0]   r_dbus_wdata;
    logic [BE_W-1:0]   r_dbus_be;
    logic [OFF_W-1:0]  r_ld_off;
    logic [1:0]        r_ld_size;
    logic              r_ld_uns;
    logic              r_ld_kill;

    logic [OFF_W-1:0]  w_off;
    logic [XLEN-1:0]   w_aaddr;
    logic [7:0]        w_mask8;
    logic              w_mis;
    logic [BE_W-1:0]   w_be;
    logic [XLEN-1:0]   w_wdata_sh;
    logic              w_hit;
    logic [PTR_W-1:0]  w_hit_idx;
    logic [PTR_W-1:0]  w_scan_idx;
    logic              w_cover;
    logic [XLEN-1:0]   w_fwd;
    logic [XLEN-1:0]   w_bus_ld;
    logic              w_pop;
    logic              w_ld_done;
    logic              w_ready;
    logic              w_acc;
    logic              w_enq;
    logic              w_ld_issue;

    // Select the loaded field, then sign- or zero-extend it to XLEN.
    function automatic logic [XLEN-1:0] f_ext(input logic [XLEN-1:0] d,
                                              input logic [1:0] sz,
                                              input logic uns);
        logic [XLEN-1:0] m;
        logic            s;
        case (sz)
            2'd0:    begin m = XLEN'(64'hFF);        s = d[7];  end
            2'd1:    begin m = XLEN'(64'hFFFF);      s = d[15]; end
            2'd2:    begin m = XLEN'(64'hFFFF_FFFF); s = d[31]; end
            default: begin m = '1;                   s = 1'b0;  end
        endcase
        return (d & m) | ((s && !uns) ? ~m : '0);
    endfunction

    assign w_off      = bus.req_addr[OFF_W-1:0];
    assign w_aaddr    = {bus.req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign w_be       = BE_W'({8'h00, w_mask8} << w_off);
    assign w_wdata_sh = bus.req_wdata << {w_off, 3'b000};

    always_comb begin
        w_mask8 = 8'h01;
        w_mis   = 1'b0;
        case (bus.req_size)
            2'd0:    begin w_mask8 = 8'h01; w_mis = 1'b0;                end
            2'd1:    begin w_mask8 = 8'h03; w_mis = bus.req_addr[0];     end
            2'd2:    begin w_mask8 = 8'h0F; w_mis = |bus.req_addr[1:0];  end
            default: begin w_mask8 = 8'hFF; w_mis = |bus.req_addr[2:0];  end
        endcase
    end

    // Scan oldest to youngest so the last match found is the youngest.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_scan_idx = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            w_scan_idx = r_head + PTR_W'(i);
            if (r_sb_vld[w_scan_idx] && (r_sb_addr[w_scan_idx] == w_aaddr)) begin
                w_hit     = 1'b1;
                w_hit_idx = w_scan_idx;
            end
        end
    end

    assign w_cover   = ((r_sb_be[w_hit_idx] & w_be) == w_be);
    assign w_fwd     = f_ext(r_sb_data[w_hit_idx] >> {w_off, 3'b000},
                             bus.req_size, bus.req_unsigned);
    assign w_bus_ld  = f_ext(bus.dbus_rdata >> {r_ld_off, 3'b000},
                             r_ld_size, r_ld_uns);
    assign w_pop     = (r_state == S_ST_DRAIN) && bus.dbus_ack;
    assign w_ld_done = (r_state == S_LD_BUS) && bus.dbus_ack;

    // Nothing is accepted while a bus load completes, so two responses never collide.
    always_comb begin
        w_ready = 1'b0;
        if (!bus.flush && !w_ld_done) begin
            if (bus.req_st)
                w_ready = w_mis || (r_count < FULL_CNT) || w_pop;
            else if (bus.req_ld && (r_state == S_IDLE))
                w_ready = w_mis || !w_hit || w_cover;
        end
    end

    assign w_acc      = bus.req_valid && w_ready;
    assign w_enq      = w_acc && bus.req_st && !w_mis;
    assign w_ld_issue = w_acc && bus.req_ld && !bus.req_st && !w_mis && !w_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_sb_vld     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_mis    <= 1'b0;
            r_rsp_rdata  <= '0;
            r_dbus_req   <= 1'b0;
            r_dbus_we    <= 1'b0;
            r_dbus_addr  <= '0;
            r_dbus_wdata <= '0;
            r_dbus_be    <= '0;
            r_ld_off     <= '0;
            r_ld_size    <= 2'd0;
            r_ld_uns     <= 1'b0;
            r_ld_kill    <= 1'b0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                r_sb_addr[i] <= '0;
                r_sb_data[i] <= '0;
                r_sb_be[i]   <= '0;
            end
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_mis   <= 1'b0;
            r_rsp_rdata <= '0;

            if (w_acc) begin
                if (w_mis) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_mis   <= 1'b1;
                end else if (bus.req_st || w_hit) begin
                    r_rsp_valid <= 1'b1;
                    if (!bus.req_st)
                        r_rsp_rdata <= w_fwd;
                end
            end

            // Pop before enqueue: on a full buffer both target the same slot.
            if (w_pop) begin
                r_sb_vld[r_head] <= 1'b0;
                r_head           <= r_head + 1'b1;
            end
            if (w_enq) begin
                r_sb_addr[r_tail] <= w_aaddr;
                r_sb_data[r_tail] <= w_wdata_sh;
                r_sb_be[r_tail]   <= w_be;
                r_sb_vld[r_tail]  <= 1'b1;
                r_tail            <= r_tail + 1'b1;
            end
            if (w_enq && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_enq && w_pop)
                r_count <= r_count - 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_ld_issue) begin
                        r_state      <= S_LD_BUS;
                        r_dbus_req   <= 1'b1;
                        r_dbus_we    <= 1'b0;
                        r_dbus_addr  <= w_aaddr;
                        r_dbus_wdata <= '0;
                        r_dbus_be    <= w_be;
                        r_ld_off     <= w_off;
                        r_ld_size    <= bus.req_size;
                        r_ld_uns     <= bus.req_unsigned;
                        r_ld_kill    <= 1'b0;
                    end else if (r_count != '0) begin
                        r_state      <= S_ST_DRAIN;
                        r_dbus_req   <= 1'b1;
                        r_dbus_we    <= 1'b1;
                        r_dbus_addr  <= r_sb_addr[r_head];
                        r_dbus_wdata <= r_sb_data[r_head];
                        r_dbus_be    <= r_sb_be[r_head];
                    end
                end
                S_LD_BUS: begin
                    if (bus.flush)
                        r_ld_kill <= 1'b1;
                    if (bus.dbus_ack) begin
                        r_state      <= S_IDLE;
                        r_dbus_req   <= 1'b0;
                        r_dbus_we    <= 1'b0;
                        r_dbus_addr  <= '0;
                        r_dbus_wdata <= '0;
                        r_dbus_be    <= '0;
                        if (!r_ld_kill && !bus.flush) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_bus_ld;
                        end
                    end
                end
                S_ST_DRAIN: begin
                    if (bus.dbus_ack) begin
                        r_state      <= S_IDLE;
                        r_dbus_req   <= 1'b0;
                        r_dbus_we    <= 1'b0;
                        r_dbus_addr  <= '0;
                        r_dbus_wdata <= '0;
                        r_dbus_be    <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready      = w_ready;
    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_misaligned = r_rsp_mis;
    assign bus.rsp_rdata      = r_rsp_rdata;
    assign bus.dbus_req       = r_dbus_req;
    assign bus.dbus_we        = r_dbus_we;
    assign bus.dbus_addr      = r_dbus_addr;
    assign bus.dbus_wdata     = r_dbus_wdata;
    assign bus.dbus_be        = r_dbus_be;
    assign bus.sb_count       = r_count;

endmodule

`default_nettype wire

// File: tb/tb_lsu_stbuf.sv
// ============================================================================
// Module  : tb_lsu_stbuf
// Brief   : Directed-vector bench for lsu_stbuf (XLEN=32, SB_DEPTH=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lsu_stbuf;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec  = 0;
    int   n_fail = 0;

    lsu_stbuf_if #(.XLEN(32), .SB_DEPTH(4)) bus ();

    lsu_stbuf #(.XLEN(32), .SB_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        bus.req_valid    = 1'b0;
        bus.req_ld       = 1'b0;
        bus.req_st       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
    endtask

    task automatic set_req(input logic ld, input logic st, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] d);
        bus.req_valid    = 1'b1;
        bus.req_ld       = ld;
        bus.req_st       = st;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'hA5A5A5A5);
        bus.dbus_ack = 1'b1;
        step(); step();
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got %b want 0", bus.rsp_valid); end
        n_vec++; if (bus.dbus_req !== 1'b0) begin n_fail++; $display("FAIL rst_dbus_req got %b want 0", bus.dbus_req); end
        n_vec++; if (bus.sb_count !== 3'd0) begin n_fail++; $display("FAIL rst_sb_count got %0d want 0", bus.sb_count); end
        n_vec++; if ({bus.dbus_addr, bus.dbus_wdata, bus.rsp_rdata} !== 96'h0) begin n_fail++; $display("FAIL rst_data got %h/%h/%h want 0", bus.dbus_addr, bus.dbus_wdata, bus.rsp_rdata); end
        n_vec++; if ({bus.dbus_be, bus.dbus_we, bus.rsp_misaligned} !== 6'h0) begin n_fail++; $display("FAIL rst_ctl got be=%b we=%b mis=%b want 0", bus.dbus_be, bus.dbus_we, bus.rsp_misaligned); end
        clr_req();
        bus.dbus_ack = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_store_drain();
        set_req(1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h0000BEEF);
        #1;
        n_vec++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL sh_ready got %b want 1", bus.req_ready); end
        step(); clr_req();
        n_vec++; if ({bus.rsp_valid, bus.rsp_misaligned} !== 2'b10) begin n_fail++; $display("FAIL sh_rsp got v=%b mis=%b want 1/0", bus.rsp_valid, bus.rsp_misaligned); end
        n_vec++; if (bus.sb_count !== 3'd1) begin n_fail++; $display("FAIL sh_count got %0d want 1", bus.sb_count); end
        step();
        n_vec++; if ({bus.dbus_req, bus.dbus_we} !== 2'b11) begin n_fail++; $display("FAIL sh_drain_req got req=%b we=%b want 1/1", bus.dbus_req, bus.dbus_we); end
        n_vec++; if (bus.dbus_addr !== 32'h100) begin n_fail++; $display("FAIL sh_drain_addr got %h want 00000100", bus.dbus_addr); end
        n_vec++; if (bus.dbus_be !== 4'b1100) begin n_fail++; $display("FAIL sh_drain_be got %b want 1100", bus.dbus_be); end
        n_vec++; if (bus.dbus_wdata !== 32'hBEEF0000) begin n_fail++; $display("FAIL sh_drain_wdata got %h want beef0000", bus.dbus_wdata); end
        bus.dbus_ack = 1'b1; step(); bus.dbus_ack = 1'b0;
        n_vec++; if ({bus.dbus_req, bus.sb_count} !== 4'b0000) begin n_fail++; $display("FAIL sh_pop got req=%b cnt=%0d want 0/0", bus.dbus_req, bus.sb_count); end
    endtask

    task automatic test_forward();
        set_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h200, 32'h11223344);
        step();
        set_req(1'b1, 1'b0, 2'd0, 1'b0, 32'h203, 32'h0);
        #1;
        n_vec++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL fwd_ready got %b want 1", bus.req_ready); end
        step(); clr_req();
        n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h00000011) begin n_fail++; $display("FAIL fwd_data got v=%b d=%h want 1/00000011", bus.rsp_valid, bus.rsp_rdata); end
        n_vec++; if ({bus.dbus_req, bus.dbus_we} !== 2'b11 || bus.dbus_addr !== 32'h200) begin n_fail++; $display("FAIL fwd_bus got req=%b we=%b a=%h want store drain @200", bus.dbus_req, bus.dbus_we, bus.dbus_addr); end
        bus.dbus_ack = 1'b1; step(); bus.dbus_ack = 1'b0;
        n_vec++; if (bus.sb_count !== 3'd0) begin n_fail++; $display("FAIL fwd_count got %0d want 0", bus.sb_count); end
    endtask

    task automatic test_stall();
        set_req(1'b0, 1'b1, 2'd0, 1'b0, 32'h300, 32'h80);
        step();
        set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
        #1;
        n_vec++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready0 got %b want 0", bus.req_ready); end
        step();
        n_vec++; if (bus.req_ready !== 1'b0 || bus.dbus_we !== 1'b1 || bus.dbus_be !== 4'b0001 || bus.dbus_wdata !== 32'h80) begin n_fail++; $display("FAIL stall_drain got rdy=%b we=%b be=%b wd=%h want 0/1/0001/80", bus.req_ready, bus.dbus_we, bus.dbus_be, bus.dbus_wdata); end
        bus.dbus_ack = 1'b1; step(); bus.dbus_ack = 1'b0;
        #1;
        n_vec++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got %b want 1", bus.req_ready); end
        step(); clr_req();
        n_vec++; if ({bus.dbus_req, bus.dbus_we} !== 2'b10 || bus.dbus_addr !== 32'h300 || bus.dbus_be !== 4'hF) begin n_fail++; $display("FAIL stall_issue got req=%b we=%b a=%h be=%b want 1/0/300/1111", bus.dbus_req, bus.dbus_we, bus.dbus_addr, bus.dbus_be); end
        bus.dbus_rdata = 32'h12345680; bus.dbus_ack = 1'b1; step(); bus.dbus_ack = 1'b0;
        n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h12345680) begin n_fail++; $display("FAIL stall_rsp got v=%b d=%h want 1/12345680", bus.rsp_valid, bus.rsp_rdata); end
    endtask

    task automatic test_load_ext();
        logic [31:0] t_addr [3] = '{32'h106, 32'h101, 32'h101};
        logic [1:0]  t_size [3] = '{2'd1, 2'd0, 2'd0};
        logic        t_uns  [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] t_rd   [3] = '{32'h80010000, 32'h0000F000, 32'h0000F000};
        logic [3:0]  t_be   [3] = '{4'b1100, 4'b0010, 4'b0010};
        logic [31:0] t_exp  [3] = '{32'hFFFF8001, 32'h000000F0, 32'hFFFFFFF0};
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 1'b0, t_size[i], t_uns[i], t_addr[i], 32'h0);
            step(); clr_req();
            n_vec++; if (bus.dbus_req !== 1'b1 || bus.dbus_be !== t_be[i]) begin n_fail++; $display("FAIL ext%0d_issue got req=%b be=%b want 1/%b", i, bus.dbus_req, bus.dbus_be, t_be[i]); end
            step();
            n_vec++; if (bus.rsp_valid !== 1'b0 || bus.dbus_req !== 1'b1) begin n_fail++; $display("FAIL ext%0d_hold got v=%b req=%b want 0/1", i, bus.rsp_valid, bus.dbus_req); end
            bus.dbus_rdata = t_rd[i]; bus.dbus_ack = 1'b1; step(); bus.dbus_ack = 1'b0;
            n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== t_exp[i]) begin n_fail++; $display("FAIL ext%0d_data got v=%b d=%h want 1/%h", i, bus.rsp_valid, bus.rsp_rdata, t_exp[i]); end
        end
        step();
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ext_pulse got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_misaligned();
        set_req(1'b1, 1'b0, 2'd1, 1'b0, 32'h101, 32'h0);
        #1;
        n_vec++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL mis_ready got %b want 1", bus.req_ready); end
        step(); clr_req();
        n_vec++; if ({bus.rsp_valid, bus.rsp_misaligned} !== 2'b11 || bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL mis_lh_rsp got v=%b mis=%b d=%h want 1/1/0", bus.rsp_valid, bus.rsp_misaligned, bus.rsp_rdata); end
        step();
        n_vec++; if (bus.dbus_req !== 1'b0) begin n_fail++; $display("FAIL mis_lh_bus got %b want 0", bus.dbus_req); end
        set_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h202, 32'h12345678);
        step(); clr_req();
        n_vec++; if (bus.rsp_misaligned !== 1'b1 || bus.sb_count !== 3'd0) begin n_fail++; $display("FAIL mis_sw got mis=%b cnt=%0d want 1/0", bus.rsp_misaligned, bus.sb_count); end
        step();
        n_vec++; if (bus.dbus_req !== 1'b0) begin n_fail++; $display("FAIL mis_sw_bus got %b want 0", bus.dbus_req); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            set_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h400 + 32'(4 * i), 32'(i + 1));
            #1;
            n_vec++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL full_st%0d_ready got %b want 1", i, bus.req_ready); end
            step();
        end
        n_vec++; if (bus.sb_count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", bus.sb_count); end
        set_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h410, 32'd5);
        #1;
        n_vec++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", bus.req_ready); end
        step();
        n_vec++; if (bus.sb_count !== 3'd4 || bus.dbus_addr !== 32'h400) begin n_fail++; $display("FAIL full_hold got cnt=%0d a=%h want 4/400", bus.sb_count, bus.dbus_addr); end
        bus.dbus_ack = 1'b1;
        #1;
        n_vec++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL full_ack_ready got %b want 1", bus.req_ready); end
        step(); clr_req(); bus.dbus_ack = 1'b0;
        n_vec++; if (bus.sb_count !== 3'd4) begin n_fail++; $display("FAIL full_swap_count got %0d want 4", bus.sb_count); end
        for (int k = 0; k < 4; k++) begin
            int t = 0;
            while (bus.dbus_req !== 1'b1 && t < 10) begin step(); t++; end
            n_vec++; if (bus.dbus_addr !== 32'h404 + 32'(4 * k) || bus.dbus_wdata !== 32'(k + 2)) begin n_fail++; $display("FAIL full_drain%0d got a=%h d=%h want %h/%h", k, bus.dbus_addr, bus.dbus_wdata, 32'h404 + 32'(4 * k), 32'(k + 2)); end
            bus.dbus_ack = 1'b1; step(); bus.dbus_ack = 1'b0;
        end
        n_vec++; if (bus.sb_count !== 3'd0) begin n_fail++; $display("FAIL full_empty got %0d want 0", bus.sb_count); end
    endtask

    task automatic test_flush();
        set_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h500, 32'h1); bus.flush = 1'b1;
        #1;
        n_vec++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_reject got %b want 0", bus.req_ready); end
        step(); clr_req(); bus.flush = 1'b0;
        n_vec++; if (bus.sb_count !== 3'd0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_noenq got cnt=%0d v=%b want 0/0", bus.sb_count, bus.rsp_valid); end
        set_req(1'b1, 1'b0, 2'd0, 1'b1, 32'h500, 32'h0);
        step(); clr_req();
        bus.flush = 1'b1; step(); bus.flush = 1'b0;
        step(); step();
        bus.dbus_rdata = 32'hFF; bus.dbus_ack = 1'b1; step(); bus.dbus_ack = 1'b0;
        n_vec++; if (bus.rsp_valid !== 1'b0 || bus.dbus_req !== 1'b0) begin n_fail++; $display("FAIL flush_kill got v=%b req=%b want 0/0", bus.rsp_valid, bus.dbus_req); end
        set_req(1'b1, 1'b0, 2'd0, 1'b1, 32'h504, 32'h0);
        #1;
        n_vec++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle got rdy=%b v=%b want 1/0", bus.req_ready, bus.rsp_valid); end
        step(); clr_req();
        bus.dbus_rdata = 32'h000000AB; bus.dbus_ack = 1'b1; step(); bus.dbus_ack = 1'b0;
        n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hAB) begin n_fail++; $display("FAIL flush_next got v=%b d=%h want 1/000000ab", bus.rsp_valid, bus.rsp_rdata); end
    endtask

    task automatic test_reset_mid();
        set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h600, 32'h0);
        step();
        set_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h700, 32'h77);
        #1;
        n_vec++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_st_during_ld got %b want 1", bus.req_ready); end
        step(); clr_req();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        n_vec++; if (bus.dbus_req !== 1'b0 || bus.sb_count !== 3'd0) begin n_fail++; $display("FAIL rmid_abandon got req=%b cnt=%0d want 0/0", bus.dbus_req, bus.sb_count); end
        bus.dbus_rdata = 32'h55; bus.dbus_ack = 1'b1; step(); bus.dbus_ack = 1'b0;
        n_vec++; if (bus.rsp_valid !== 1'b0 || bus.dbus_req !== 1'b0) begin n_fail++; $display("FAIL rmid_late_ack got v=%b req=%b want 0/0", bus.rsp_valid, bus.dbus_req); end
    endtask

    initial begin
        clr_req();
        bus.flush      = 1'b0;
        bus.dbus_ack   = 1'b0;
        bus.dbus_rdata = '0;
        test_reset();
        test_store_drain();
        test_forward();
        test_stall();
        test_load_ext();
        test_misaligned();
        test_full();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
